axi_sram_arbiter: RTL and testbench

- Shares one axi_sram_intf slave between NREQ requesters, each using a simple req/we/addr/wdata interface.
- Per requester transaction, sequences the slave's AXI-lite channels strictly in order: AW, then W, then B for writes; AR, then R for reads.
- Drives the slave's wr_en (active low) and chip_en.
- Round-robin arbitration, one outstanding transaction, per-phase handshake timeout.

---
 rtl/axi_sram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_axi_sram_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_arbiter.sv
// Round-robin arbiter sharing one AXI-lite SRAM slave between NREQ simple
// req/we/addr/wdata requesters; one transaction at a time with per-phase timeout.
module axi_sram_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               aclk,
    input  logic               areset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [DW-1:0]      rdata,
    output logic               resp,
    output logic               s_wr_en,
    output logic               s_chip_en,
    output logic [AW-1:0]      s_awaddr,
    output logic               s_awvalid,
    input  logic               s_awready,
    output logic [DW-1:0]      s_wdata,
    output logic               s_wvalid,
    input  logic               s_wready,
    output logic [AW-1:0]      s_araddr,
    output logic               s_arvalid,
    input  logic               s_arready,
    input  logic [DW-1:0]      s_rdata,
    input  logic               s_rvalid,
    output logic               s_rready,
    input  logic               s_bvalid,
    input  logic               s_bresp,
    output logic               s_bready
);

    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]  TMAX = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

    state_t          state_q, state_d, hs_next;
    logic [IW-1:0]   rr_q, rr_d, sel;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            resp_q, resp_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            found, wait_hs, hs;
    int unsigned     idx_w;

    logic [AW-1:0]   addr_a  [NREQ];
    logic [DW-1:0]   wdata_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = addr[g*AW +: AW];
        assign wdata_a[g] = wdata[g*DW +: DW];
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        cnt_d   = '0;
        found   = 1'b0;
        wait_hs = 1'b0;
        hs      = 1'b0;
        hs_next = state_q;
        sel     = '0;
        idx_w   = 0;
        unique case (state_q)
            IDLE: begin
                // Search upward from rr+1 with wrap; first hit wins.
                for (int unsigned k = 1; k <= NREQ; k++) begin
                    idx_w = (32'(rr_q) + k) % NREQ;
                    sel   = IW'(idx_w);
                    if (!found && req[sel]) begin
                        found      = 1'b1;
                        gnt_d      = '0;
                        gnt_d[sel] = 1'b1;
                        addr_d     = addr_a[sel];
                        wdata_d    = wdata_a[sel];
                        rr_d       = sel;
                        state_d    = we[sel] ? WADDR : RADDR;
                    end
                end
            end
            WADDR: begin wait_hs = 1'b1; hs = s_awready; hs_next = WDATA; end
            WDATA: begin wait_hs = 1'b1; hs = s_wready;  hs_next = WRESP; end
            WRESP: begin
                wait_hs = 1'b1; hs = s_bvalid; hs_next = DONE;
                if (s_bvalid) resp_d = s_bresp;
            end
            RADDR: begin wait_hs = 1'b1; hs = s_arready; hs_next = RDATA; end
            RDATA: begin
                wait_hs = 1'b1; hs = s_rvalid; hs_next = DONE;
                if (s_rvalid) begin
                    rdata_d = s_rdata;
                    resp_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        // Shared handshake/timeout handling for every waiting phase.
        if (wait_hs) begin
            if (hs) begin
                state_d = hs_next;
            end else if (cnt_q == TMAX) begin
                state_d = DONE;
                resp_d  = 1'b1;
                rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= IDLE;
            rr_q    <= IW'(NREQ - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_awvalid = (state_q == WADDR);
    assign s_wvalid  = (state_q == WDATA);
    assign s_bready  = (state_q == WRESP);
    assign s_arvalid = (state_q == RADDR);
    assign s_rready  = (state_q == RDATA);
    assign s_awaddr  = s_awvalid ? addr_q  : '0;
    assign s_wdata   = s_wvalid  ? wdata_q : '0;
    assign s_araddr  = s_arvalid ? addr_q  : '0;
    assign s_wr_en   = !(s_awvalid || s_wvalid || s_bready);
    assign s_chip_en = (state_q != IDLE);
    assign gnt       = gnt_q;
    assign done      = (state_q == DONE) ? gnt_q : '0;
    assign rdata     = rdata_q;
    assign resp      = resp_q;

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Scoreboard bench for axi_sram_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_axi_sram_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned TO   = 16;

    logic               aclk = 1'b0;
    logic               areset_n = 1'b0;
    logic [NREQ-1:0]    req = '0, we = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    gnt, done;
    logic [DW-1:0]      rdata;
    logic               resp, s_wr_en, s_chip_en;
    logic [AW-1:0]      s_awaddr, s_araddr;
    logic [DW-1:0]      s_wdata, s_rdata;
    logic               s_awvalid, s_awready, s_wvalid, s_wready;
    logic               s_arvalid, s_arready, s_rvalid, s_rready;
    logic               s_bvalid, s_bresp, s_bready;

    axi_sram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .aclk(aclk), .areset_n(areset_n), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .done(done), .rdata(rdata), .resp(resp),
        .s_wr_en(s_wr_en), .s_chip_en(s_chip_en), .s_awaddr(s_awaddr),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_wdata(s_wdata),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_araddr(s_araddr),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_bvalid(s_bvalid),
        .s_bresp(s_bresp), .s_bready(s_bready)
    );

    always #5 aclk = ~aclk;

    // Slave model knobs
    logic        aw_ok = 1'b1, w_ok = 1'b1, bresp_v = 1'b0;
    logic [31:0] sl_rdata = '0;
    int          r_delay = 1;
    int          rcnt = 0;
    int          cyc = 0;

    always @(posedge aclk) begin
        cyc  <= cyc + 1;
        rcnt <= s_rready ? rcnt + 1 : 0;
    end

    always_comb begin
        s_awready = aw_ok;
        s_wready  = w_ok;
        s_arready = 1'b1;
        s_bvalid  = s_bready;
        s_bresp   = bresp_v;
        s_rvalid  = s_rready && (rcnt >= r_delay - 1);
        s_rdata   = sl_rdata;
    end

    typedef struct {
        int          idx;
        bit          chk_rd;
        logic [31:0] rdata;
        bit          resp;
        int          n_wren;
        int          n_addr;
        int          n_rr;
        int          lat;
        logic [31:0] addr;
        bit          chk_wd;
        logic [31:0] wdata;
        int          t_issue;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: per-transaction tallies, compared against the scoreboard at done.
    int          m_wren = 0, m_addr = 0, m_rr = 0;
    logic [31:0] m_seen_addr = '0, m_seen_wd = '0;

    always @(negedge aclk) begin
        exp_t        e;
        logic [NREQ-1:0] ev;
        if (!areset_n) begin
            m_wren = 0; m_addr = 0; m_rr = 0; m_seen_addr = '0; m_seen_wd = '0;
        end else begin
            if (!s_wr_en) m_wren++;
            if (s_awvalid) begin m_addr++; m_seen_addr = s_awaddr; end
            if (s_arvalid) begin m_addr++; m_seen_addr = s_araddr; end
            if (s_rready) m_rr++;
            if (s_wvalid) m_seen_wd = s_wdata;
            if (gnt != '0) check("gnt_onehot", 64'($countones(gnt)), 64'd1);
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    ev = '0;
                    ev[e.idx] = 1'b1;
                    check("done_vec", 64'(done), 64'(ev));
                    check("gnt_at_done", 64'(gnt), 64'(ev));
                    check("resp", 64'(resp), 64'(e.resp));
                    if (e.chk_rd) check("rdata", 64'(rdata), 64'(e.rdata));
                    check("wr_en_low_cycles", 64'(m_wren), 64'(e.n_wren));
                    check("addr_valid_cycles", 64'(m_addr), 64'(e.n_addr));
                    check("rready_cycles", 64'(m_rr), 64'(e.n_rr));
                    check("slave_addr", 64'(m_seen_addr), 64'(e.addr));
                    if (e.chk_wd) check("slave_wdata", 64'(m_seen_wd), 64'(e.wdata));
                    if (e.lat != 0) check("latency", 64'(cyc - e.t_issue), 64'(e.lat));
                end
                m_wren = 0; m_addr = 0; m_rr = 0; m_seen_addr = '0; m_seen_wd = '0;
            end
        end
    end

    task automatic do_txn(input int idx, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit chk_rd, input logic [31:0] erd, input bit eresp,
                          input int nwren, input int naddr, input int nrr, input int lat);
        exp_t e;
        bit   got;
        @(negedge aclk);
        e.idx = idx; e.chk_rd = chk_rd; e.rdata = erd; e.resp = eresp;
        e.n_wren = nwren; e.n_addr = naddr; e.n_rr = nrr; e.lat = lat;
        e.addr = a; e.chk_wd = w && !eresp; e.wdata = d; e.t_issue = cyc;
        sb.push_back(e);
        we[idx] = w;
        addr[idx*AW +: AW] = a;
        wdata[idx*DW +: DW] = d;
        req[idx] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge aclk);
            if (done[idx]) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 64'd0, 64'd1);
            sb.delete();
        end
        req[idx] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset_n = 1'b0;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  nd;
        bit  got;

        // Reset state
        @(negedge aclk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_en", 64'(s_wr_en), 64'd1);
        check("rst_chip_en", 64'(s_chip_en), 64'd0);
        check("rst_valids", 64'({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}), 64'd0);
        check("rst_rdata_resp", 64'({rdata, resp}), 64'd0);
        check("rst_awaddr", 64'(s_awaddr), 64'd0);
        @(negedge aclk);
        areset_n = 1'b1;

        // Single write, then read back with 3-cycle rvalid delay
        do_txn(0, 1'b1, 32'hfade_cafe, 32'h1234, 1'b0, '0, 1'b0, 3, 1, 0, 4);
        r_delay = 3; sl_rdata = 32'h1234;
        do_txn(0, 1'b0, 32'hfade_cafe, 32'h0, 1'b1, 32'h1234, 1'b0, 0, 1, 3, 5);

        // Both requesting reads continuously: alternating grants from reset
        do_reset();
        r_delay = 1; sl_rdata = 32'h5555_aaaa;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.idx = i % 2; e.chk_rd = 1'b1; e.rdata = 32'h5555_aaaa; e.resp = 1'b0;
            e.n_wren = 0; e.n_addr = 1; e.n_rr = 1; e.lat = 0;
            e.addr = (i % 2 == 0) ? 32'h100 : 32'h200;
            e.chk_wd = 1'b0; e.wdata = '0; e.t_issue = 0;
            sb.push_back(e);
        end
        @(negedge aclk);
        we = '0;
        addr = {32'h200, 32'h100};
        req = 2'b11;
        nd = 0;
        for (int i = 0; i < 200 && nd < 4; i++) begin
            @(negedge aclk);
            if (done != '0) nd++;
        end
        req = '0;
        check("alt_done_count", 64'(nd), 64'd4);

        // Error response, then a normal write
        bresp_v = 1'b1;
        do_txn(1, 1'b1, 32'hdead_beef, 32'h77, 1'b0, '0, 1'b1, 3, 1, 0, 4);
        bresp_v = 1'b0;
        do_txn(0, 1'b1, 32'h10, 32'h99, 1'b0, '0, 1'b0, 3, 1, 0, 4);

        // AW never ready: timeout after TO cycles of awvalid, rdata forced to 0
        aw_ok = 1'b0;
        do_txn(0, 1'b1, 32'h20, 32'h55, 1'b1, 32'h0, 1'b1, TO, TO, 0, TO + 1);
        aw_ok = 1'b1;
        @(negedge aclk);
        check("to_idle_chip_en", 64'(s_chip_en), 64'd0);
        check("to_idle_gnt", 64'(gnt), 64'd0);

        // Reset while stalled in WDATA
        w_ok = 1'b0;
        @(negedge aclk);
        we[0] = 1'b1; addr[AW-1:0] = 32'h40; wdata[DW-1:0] = 32'habcd; req[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge aclk);
            if (s_wvalid) got = 1'b1;
        end
        check("reach_wdata", 64'(got), 64'd1);
        #2 areset_n = 1'b0;
        #1;
        check("arst_valids", 64'({s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}), 64'd0);
        check("arst_gnt", 64'(gnt), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_chip_en", 64'(s_chip_en), 64'd0);
        req[0] = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        areset_n = 1'b1;
        w_ok = 1'b1;
        repeat (5) @(negedge aclk);
        check("post_rst_gnt", 64'(gnt), 64'd0);
        do_txn(0, 1'b1, 32'h44, 32'hbeef, 1'b0, '0, 1'b0, 3, 1, 0, 4);

        repeat (5) @(negedge aclk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
